// File: rtl/mem_map_ctrl.sv
// mem_map_ctrl: decodes MAB into RAM/ROM/unmapped space with per-region wait states.
// Holds the RAM array internally and drives an external ROM read port.
module mem_map_ctrl #(
  parameter logic [15:0] RAM_BASE  = 16'h0200,
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [15:0] ROM_BASE  = 16'hC000,
  parameter logic [3:0]  RAM_WS    = 4'd0,
  parameter logic [3:0]  ROM_WS    = 4'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] MAB_in,
  input  logic [15:0] MDB_in,
  input  logic        MW,
  input  logic        BW,
  output logic [15:0] MDB_out,
  output logic        rdy,
  output logic        fault,
  output logic [15:0] fault_addr,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data
);

  localparam int IW = $clog2(RAM_WORDS);
  // exclusive upper bound of the RAM window, widened so it cannot wrap
  localparam logic [16:0] RAM_END = {1'b0, RAM_BASE} + 17'(2 * RAM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  logic [15:0] mem [RAM_WORDS];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0] wdata_q, wdata_d;
  logic        mw_q, mw_d;
  logic        bw_q, bw_d;
  logic        lane_q, lane_d;
  logic        is_rom_q, is_rom_d;
  logic        rdy_q, rdy_d;
  logic        fault_q, fault_d;
  logic [15:0] mdb_out_q, mdb_out_d;
  logic [15:0] fault_addr_q, fault_addr_d;
  logic [15:0] rom_addr_q, rom_addr_d;

  logic        ram_hit, rom_hit;
  logic        f_unmap, f_align, f_rom_wr, f_any;
  logic [15:0] ram_off, rom_off;
  logic [15:0] src_word, rd_val;
  logic        accept, commit;

  // Address decode of the incoming request
  always_comb begin
    ram_off  = MAB_in - RAM_BASE;
    rom_off  = MAB_in - ROM_BASE;
    ram_hit  = (MAB_in >= RAM_BASE) && ({1'b0, MAB_in} < RAM_END);
    rom_hit  = (MAB_in >= ROM_BASE);
    f_unmap  = !ram_hit && !rom_hit;
    f_align  = !f_unmap && !BW && MAB_in[0];
    f_rom_wr = !f_unmap && !f_align && rom_hit && MW;
    f_any    = f_unmap || f_align || f_rom_wr;
  end

  // Read data formatting: word, or zero-extended selected byte lane
  always_comb begin
    src_word = is_rom_q ? rom_data : mem[idx_q];
    rd_val   = src_word;
    if (bw_q) begin
      rd_val = {8'h00, lane_q ? src_word[15:8] : src_word[7:0]};
    end
  end

  // Next-state and registered output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    mw_d         = mw_q;
    bw_d         = bw_q;
    lane_d       = lane_q;
    is_rom_d     = is_rom_q;
    rdy_d        = 1'b0;
    fault_d      = 1'b0;
    mdb_out_d    = mdb_out_q;
    fault_addr_d = fault_addr_q;
    rom_addr_d   = rom_addr_q;
    accept       = 1'b0;
    commit       = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (req) begin
          accept   = 1'b1;
          wdata_d  = MDB_in;
          mw_d     = MW;
          bw_d     = BW;
          lane_d   = MAB_in[0];
          is_rom_d = rom_hit;
          if (f_any) begin
            state_d      = DONE;
            rdy_d        = 1'b1;
            fault_d      = 1'b1;
            fault_addr_d = MAB_in;
          end else begin
            state_d = WAIT;
            if (rom_hit) begin
              cnt_d      = ROM_WS;
              rom_addr_d = {1'b0, rom_off[15:1]};
            end else begin
              cnt_d = RAM_WS;
              idx_d = ram_off[IW:1];
            end
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = DONE;
          rdy_d   = 1'b1;
          if (!mw_q) begin
            mdb_out_d = rd_val;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      idx_q        <= '0;
      wdata_q      <= 16'h0000;
      mw_q         <= 1'b0;
      bw_q         <= 1'b0;
      lane_q       <= 1'b0;
      is_rom_q     <= 1'b0;
      rdy_q        <= 1'b0;
      fault_q      <= 1'b0;
      mdb_out_q    <= 16'h0000;
      fault_addr_q <= 16'h0000;
      rom_addr_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      mw_q         <= mw_d;
      bw_q         <= bw_d;
      lane_q       <= lane_d;
      is_rom_q     <= is_rom_d;
      rdy_q        <= rdy_d;
      fault_q      <= fault_d;
      mdb_out_q    <= mdb_out_d;
      fault_addr_q <= fault_addr_d;
      rom_addr_q   <= rom_addr_d;
    end
  end

  // RAM write commits on the last wait cycle; a reset on that edge drops it
  always_ff @(posedge clk) begin
    if (rst_n && commit && mw_q && !is_rom_q) begin
      if (!bw_q) begin
        mem[idx_q] <= wdata_q;
      end else if (lane_q) begin
        mem[idx_q][15:8] <= wdata_q[7:0];
      end else begin
        mem[idx_q][7:0] <= wdata_q[7:0];
      end
    end
  end

  assign MDB_out    = mdb_out_q;
  assign rdy        = rdy_q;
  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;
  assign rom_addr   = rom_addr_q;

endmodule

// File: tb/tb_mem_map_ctrl.sv
// tb_mem_map_ctrl: scoreboard bench for mem_map_ctrl.
// Expectations queued at request time, checked when rdy pulses.
module tb_mem_map_ctrl;

  localparam int RAM_LAT = 1;
  localparam int ROM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [15:0] MAB_in;
  logic [15:0] MDB_in;
  logic        MW;
  logic        BW;
  logic [15:0] MDB_out;
  logic        rdy;
  logic        fault;
  logic [15:0] fault_addr;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [15:0] data;
    logic        dchk;
    logic        flt;
    logic [15:0] fa;
    int          cyc;
  } exp_t;

  exp_t q[$];

  logic [15:0] mdl [0:255];
  logic [15:0] last_rd;
  logic [15:0] fa_m;

  mem_map_ctrl #(
    .ROM_WS(4'd3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .MAB_in    (MAB_in),
    .MDB_in    (MDB_in),
    .MW        (MW),
    .BW        (BW),
    .MDB_out   (MDB_out),
    .rdy       (rdy),
    .fault     (fault),
    .fault_addr(fault_addr),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    return (a == 16'h1FFF) ? 16'hC0DE : (a ^ 16'h5A5A);
  endfunction

  assign rom_data = rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rdy) begin
      if (q.size() == 0) begin
        chk("unexp_rdy", 32'(rdy), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("lat", 32'(cyc), 32'(e.cyc));
        chk("fault", 32'(fault), 32'(e.flt));
        chk("faddr", 32'(fault_addr), 32'(e.fa));
        if (e.dchk) chk("data", 32'(MDB_out), 32'(e.data));
      end
    end else if (fault) begin
      chk("fault_wo_rdy", 32'(fault), 32'd0);
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] d,
                       input logic w, input logic b, input logic hold);
    exp_t e;
    logic ram, rom, f;
    logic [7:0] wi;
    logic [15:0] word;
    int lat;
    ram = (a >= 16'h0200) && (a <= 16'h03FF);
    rom = (a >= 16'hC000);
    f   = (!ram && !rom) || (!b && a[0]) || (rom && w);
    wi  = 8'((a - 16'h0200) >> 1);
    e.dchk = 1'b1;
    e.flt  = f;
    if (f) begin
      fa_m = a;
      lat  = 0;
      e.data = last_rd;
    end else begin
      lat = rom ? ROM_LAT : RAM_LAT;
      word = rom ? rom_fn((a - 16'hC000) >> 1) : mdl[wi];
      if (w) begin
        e.dchk = 1'b0;
        if (!b) mdl[wi] = d;
        else if (a[0]) mdl[wi][15:8] = d[7:0];
        else mdl[wi][7:0] = d[7:0];
      end else begin
        last_rd = b ? {8'h00, a[0] ? word[15:8] : word[7:0]} : word;
      end
      e.data = last_rd;
    end
    e.fa = fa_m;
    @(negedge clk);
    MAB_in = a;
    MDB_in = d;
    MW     = w;
    BW     = b;
    req    = 1'b1;
    @(posedge clk);
    #1;
    e.cyc = cyc + lat;
    q.push_back(e);
    if (!hold) req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rdy"}, 32'(rdy), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_mdb"}, 32'(MDB_out), 32'd0);
    chk({tag, "_fa"}, 32'(fault_addr), 32'd0);
    chk({tag, "_roma"}, 32'(rom_addr), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 1'b0;
    MAB_in  = 16'h0000;
    MDB_in  = 16'h0000;
    MW      = 1'b0;
    BW      = 1'b0;
    last_rd = 16'h0000;
    fa_m    = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("rst");
    rst_n = 1'b1;

    issue(16'h0200, 16'hBEEF, 1'b1, 1'b0, 1'b0); drain();
    issue(16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0); drain();
    issue(16'h0201, 16'h005A, 1'b1, 1'b1, 1'b0); drain();
    issue(16'h0201, 16'h0000, 1'b0, 1'b1, 1'b0); drain();
    issue(16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0); drain();
    issue(16'h0200, 16'h0000, 1'b0, 1'b1, 1'b0); drain();

    issue(16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("rom_addr", 32'(rom_addr), 32'h1FFF);
    repeat (2) @(posedge clk);
    #1 chk("rom_addr_hold", 32'(rom_addr), 32'h1FFF);
    drain();
    issue(16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0); drain();
    issue(16'hC004, 16'h0000, 1'b0, 1'b0, 1'b0); drain();

    issue(16'h0203, 16'h0000, 1'b0, 1'b0, 1'b0); drain();
    issue(16'h0201, 16'h1111, 1'b1, 1'b0, 1'b0); drain();
    issue(16'hC000, 16'h2222, 1'b1, 1'b0, 1'b0); drain();
    issue(16'h1000, 16'h0000, 1'b0, 1'b0, 1'b0); drain();
    issue(16'h0200, 16'h0000, 1'b0, 1'b0, 1'b0); drain();

    issue(16'h03FE, 16'hA1B2, 1'b1, 1'b0, 1'b0); drain();
    issue(16'h03FE, 16'h0000, 1'b0, 1'b0, 1'b0); drain();
    issue(16'h0400, 16'h0000, 1'b0, 1'b0, 1'b0); drain();
    issue(16'hBFFE, 16'h0000, 1'b0, 1'b0, 1'b0); drain();

    for (int i = 0; i < 4; i++) begin
      issue(16'(16'h0220 + 2 * i), 16'(16'h1000 * (i + 1) + i), 1'b1, 1'b0, 1'b1);
      @(posedge clk);
    end
    req = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) begin
      issue(16'(16'h0220 + 2 * i), 16'h0000, 1'b0, 1'b0, 1'b0); drain();
    end

    issue(16'h0210, 16'h7777, 1'b1, 1'b0, 1'b0); drain();
    @(negedge clk);
    MAB_in = 16'h0210;
    MDB_in = 16'h1234;
    MW     = 1'b1;
    BW     = 1'b0;
    req    = 1'b1;
    @(posedge clk);
    #1;
    req   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outs("midrst");
    last_rd = 16'h0000;
    fa_m    = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    issue(16'h0210, 16'h0000, 1'b0, 1'b0, 1'b0); drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
